bg_pixel_fetch: RTL and testbench
=================================

# bg_pixel_fetch

Frame-buffer read-address generator feeding the VGA display path. Walks the background image stored in pixel RAM (one 16-bit word per pixel, row-major) in raster order whenever the display raises its pixel-window enable, and issues one read per pixel so that RAM data arrives aligned with the display's 2-pixel-early window. Supports a per-frame horizontal scroll offset with wrap-around and flags window/line-count violations.

## Interface
- L, 640, image width in pixels (row stride in RAM)
- W, 480, image height in lines
- ADDR_W, 19, RAM address width; must satisfy L*W <= 2^ADDR_W
- clk_vga  in  1  pixel clock, 25.175 MHz
- rst  in  1  one clock; reset is synchronous and active-low
- y_valid  in  1  vertical sync from display, active-low; falling edge = frame start
- addr_ena  in  1  display pixel-window enable, high for L cycles per visible line
- h_off  in  11  horizontal source offset, sampled at frame start
- ram_addr  out  ADDR_W  registered RAM read address
- ram_rd_en  out  1  registered read strobe
- line_done  out  1  one-cycle pulse per completed line
- frame_done  out  1  one-cycle pulse after line W-1 completes
- overrun  out  1  sticky: addr_ena seen after W lines in current frame

## Operation
- States: IDLE (after reset, waiting for frame start), ACTIVE, HOLD (W lines done, waiting for next frame start).
- Frame start = y_valid_q==1 && y_valid==0; y_valid_q resets to 1. From any state: col=0, row=0, line_base=0, overrun=0, h_off_q = (h_off < L) ? h_off : 0, go ACTIVE.
- ACTIVE, addr_ena=1: src_col = col + h_off_q, minus L if >= L (single conditional subtract, 12-bit intermediate); ram_addr <= line_base + src_col; ram_rd_en <= 1; col increments, saturating at L-1 (extra enable cycles repeat the last pixel's address).
- ACTIVE, line end (addr_ena_q==1 && addr_ena==0): col=0, line_base += L (no multiplier), row++, line_done pulse. If row was W-1: frame_done pulse, go HOLD.
- HOLD/IDLE, addr_ena=1: no read (ram_rd_en=0); in HOLD set overrun=1.
- ram_addr holds its last value when ram_rd_en=0.
- Frame start in same cycle as addr_ena=1: frame start wins; no read issued that cycle; col remains 0.
- Frame start in same cycle as a line end: frame start wins; no line_done/frame_done.

## Timing
- Reset (rst=0 at a clk_vga edge): ram_addr=0, ram_rd_en=0, line_done=0, frame_done=0, overrun=0, state IDLE, all counters 0, addr_ena_q=0, y_valid_q=1. Reset mid-line discards progress; reads resume only after the next frame start.
- Latency: addr_ena high in cycle n -> ram_addr/ram_rd_en valid in cycle n+1 -> 1-cycle RAM data in n+2, matching the display's window that opens 2 pixels early.
- line_done/frame_done assert in the cycle after the addr_ena falling edge, for exactly one cycle.
- overrun asserts the cycle after the first offending addr_ena and holds until the next frame start or reset.
- No back-pressure; one read per enabled cycle.

## Test plan
- Reset: rst=0 for 3 cycles while addr_ena toggles -> all outputs 0; after release, addr_ena without a y_valid falling edge -> ram_rd_en stays 0.
- Raster walk (L=8, W=4, h_off=0): y_valid pulse, four 8-cycle addr_ena bursts -> ram_addr 0..31 in order one cycle after each enable; 4 line_done pulses; frame_done once after the 4th line; state HOLD.
- Scroll wrap (L=8, h_off=5): line 0 -> 5,6,7,0,1,2,3,4; line 1 -> 13,14,15,8,9,10,11,12. h_off=9 -> treated as 0, line 0 -> 0..7.
- Overrun: 5th burst in the same frame -> ram_rd_en=0, overrun=1 held; next y_valid falling edge -> overrun=0, ram_addr restarts at 0.
- Long line (L=8): addr_ena held 10 cycles -> addresses 0..7,7,7, ram_rd_en high all 10 cycles; next line starts at 8.
- Collisions: y_valid falling edge coincident with addr_ena rising -> no read that cycle, next read address 0; reset asserted mid line 2 -> outputs 0 next cycle, restart at 0 after next frame start.

Source files
------------

// File: rtl/bg_pixel_fetch_if.sv
// Display-side and RAM-side signals of the background pixel fetcher.
// master = fetcher, slave = display/RAM environment.
interface bg_pixel_fetch_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              y_valid;
  logic              addr_ena;
  logic [10:0]       h_off;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic              line_done;
  logic              frame_done;
  logic              overrun;

  modport master (
    input  y_valid, addr_ena, h_off,
    output ram_addr, ram_rd_en, line_done, frame_done, overrun
  );

  modport slave (
    output y_valid, addr_ena, h_off,
    input  ram_addr, ram_rd_en, line_done, frame_done, overrun
  );
endinterface

// File: rtl/bg_pixel_fetch.sv
// Raster-order frame-buffer read-address generator with per-frame horizontal scroll.
// One registered read per enabled pixel cycle; RAM data lands two cycles after the enable.
module bg_pixel_fetch #(
  parameter int unsigned L      = 640,
  parameter int unsigned W      = 480,
  parameter int unsigned ADDR_W = 19
) (
  input logic             clk_vga,
  input logic             rst,
  bg_pixel_fetch_if.master bus
);

  localparam int unsigned ColW = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned RowW = $clog2(W + 1);
  localparam logic [11:0] LW   = 12'(L);

  typedef enum logic [1:0] {StIdle, StActive, StHold} state_e;

  state_e              state_q, state_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0]   line_base_q, line_base_d;
  logic [10:0]         h_off_q, h_off_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_rd_en_q, ram_rd_en_d;
  logic                line_done_q, line_done_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;
  logic                y_valid_q, addr_ena_q;

  logic                frame_start, line_end;
  logic [11:0]         src_sum, src_col;

  assign frame_start = y_valid_q & ~bus.y_valid;
  assign line_end    = addr_ena_q & ~bus.addr_ena;

  // h_off_q < L, so a single conditional subtract wraps the source column.
  assign src_sum = 12'(col_q) + {1'b0, h_off_q};
  assign src_col = (src_sum >= LW) ? (src_sum - LW) : src_sum;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    line_base_d  = line_base_q;
    h_off_d      = h_off_q;
    ram_addr_d   = ram_addr_q;
    ram_rd_en_d  = 1'b0;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    if (frame_start) begin
      // Frame start overrides any coincident enable or line end.
      col_d       = '0;
      row_d       = '0;
      line_base_d = '0;
      overrun_d   = 1'b0;
      h_off_d     = ({1'b0, bus.h_off} < LW) ? bus.h_off : 11'd0;
      state_d     = StActive;
    end else begin
      case (state_q)
        StActive: begin
          if (bus.addr_ena) begin
            ram_addr_d  = line_base_q + ADDR_W'(src_col);
            ram_rd_en_d = 1'b1;
            if (col_q != ColW'(L - 1)) col_d = col_q + ColW'(1);
          end else if (line_end) begin
            col_d       = '0;
            line_base_d = line_base_q + ADDR_W'(L);
            row_d       = row_q + RowW'(1);
            line_done_d = 1'b1;
            if (row_q == RowW'(W - 1)) begin
              frame_done_d = 1'b1;
              state_d      = StHold;
            end
          end
        end
        StHold: begin
          if (bus.addr_ena) overrun_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_vga) begin
    if (!rst) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      line_base_q  <= '0;
      h_off_q      <= '0;
      ram_addr_q   <= '0;
      ram_rd_en_q  <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      y_valid_q    <= 1'b1;
      addr_ena_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      line_base_q  <= line_base_d;
      h_off_q      <= h_off_d;
      ram_addr_q   <= ram_addr_d;
      ram_rd_en_q  <= ram_rd_en_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      y_valid_q    <= bus.y_valid;
      addr_ena_q   <= bus.addr_ena;
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_rd_en  = ram_rd_en_q;
  assign bus.line_done  = line_done_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_bg_pixel_fetch.sv
// Scoreboard bench for bg_pixel_fetch (L=8, W=4): stimulus queues expected reads tagged with
// the cycle they should appear in; a negedge monitor compares every cycle.
module tb_bg_pixel_fetch;
  localparam int unsigned L      = 8;
  localparam int unsigned W      = 4;
  localparam int unsigned ADDR_W = 19;

  logic clk_vga = 1'b0;
  logic rst     = 1'b0;
  always #5 clk_vga = ~clk_vga;

  bg_pixel_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  bg_pixel_fetch #(.L(L), .W(W), .ADDR_W(ADDR_W)) dut (
    .clk_vga (clk_vga),
    .rst     (rst),
    .bus     (bus.master)
  );

  typedef struct {
    int cyc;
    int addr;
  } exp_t;

  exp_t exp_q[$];
  int   vec[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   line_cnt  = 0;
  int   frame_cnt = 0;

  always @(posedge clk_vga) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: a read is required exactly when the queue head is tagged with this cycle.
  always @(negedge clk_vga) begin
    bit   exp_rd;
    exp_t e;
    exp_rd = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    check("ram_rd_en", {63'd0, bus.ram_rd_en}, {63'd0, exp_rd});
    if (exp_rd) begin
      e = exp_q.pop_front();
      if (bus.ram_rd_en) check("ram_addr", 64'(bus.ram_addr), 64'(e.addr));
    end
    if (bus.line_done)  line_cnt++;
    if (bus.frame_done) frame_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic expect_rd(input int addr);
    exp_t e;
    e.cyc  = cyc + 1;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  // n enabled cycles; vec holds the expected address of each (empty = no reads expected).
  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      bus.addr_ena = 1'b1;
      if (i < vec.size()) expect_rd(vec[i]);
      tick();
    end
    bus.addr_ena = 1'b0;
    tick();
    tick();
  endtask

  task automatic fill_line(input int row, input int n);
    vec = {};
    for (int i = 0; i < n; i++) vec.push_back(row * L + ((i < L) ? i : L - 1));
  endtask

  task automatic frame_start();
    bus.y_valid = 1'b0;
    tick();
    bus.y_valid = 1'b1;
    tick();
  endtask

  initial begin
    int lc, fc;
    bus.y_valid  = 1'b1;
    bus.addr_ena = 1'b0;
    bus.h_off    = 11'd0;
    rst          = 1'b0;

    // Reset with addr_ena toggling
    for (int i = 0; i < 3; i++) begin
      bus.addr_ena = (i % 2 == 0);
      tick();
    end
    check("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
    check("rst_line_done", {63'd0, bus.line_done}, 64'd0);
    check("rst_frame_done", {63'd0, bus.frame_done}, 64'd0);
    check("rst_overrun", {63'd0, bus.overrun}, 64'd0);
    bus.addr_ena = 1'b0;
    rst = 1'b1;
    tick();
    vec = {};
    burst(8);

    // Raster walk, 4 lines, no scroll
    frame_start();
    for (int r = 0; r < 4; r++) begin
      fill_line(r, 8);
      burst(8);
    end
    check("raster_line_done_cnt", 64'(line_cnt), 64'd4);
    check("raster_frame_done_cnt", 64'(frame_cnt), 64'd1);
    check("raster_overrun", {63'd0, bus.overrun}, 64'd0);

    // Fifth burst in HOLD: no reads, sticky overrun
    vec = {};
    burst(8);
    check("overrun_set", {63'd0, bus.overrun}, 64'd1);
    tick(); tick(); tick();
    check("overrun_held", {63'd0, bus.overrun}, 64'd1);
    check("hold_no_line_done", 64'(line_cnt), 64'd4);
    frame_start();
    check("overrun_cleared", {63'd0, bus.overrun}, 64'd0);
    vec = '{0, 1, 2, 3, 4, 5, 6, 7};
    burst(8);

    // Scroll wrap, h_off = 5
    bus.h_off = 11'd5;
    frame_start();
    vec = '{5, 6, 7, 0, 1, 2, 3, 4};
    burst(8);
    vec = '{13, 14, 15, 8, 9, 10, 11, 12};
    burst(8);

    // Out-of-range h_off = 9 treated as 0
    bus.h_off = 11'd9;
    frame_start();
    vec = '{0, 1, 2, 3, 4, 5, 6, 7};
    burst(8);
    bus.h_off = 11'd0;

    // Long line: saturating column
    frame_start();
    vec = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7};
    burst(10);
    vec = '{8, 9, 10, 11, 12, 13, 14, 15};
    burst(8);

    // Frame start coincident with addr_ena rising: no read that cycle
    bus.y_valid  = 1'b0;
    bus.addr_ena = 1'b1;
    tick();
    bus.y_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_rd(i);
      tick();
    end
    bus.addr_ena = 1'b0;
    tick();
    tick();

    // Frame start coincident with line end: no line_done/frame_done
    lc = line_cnt;
    fc = frame_cnt;
    for (int i = 0; i < 4; i++) begin
      bus.addr_ena = 1'b1;
      expect_rd(8 + i);
      tick();
    end
    bus.addr_ena = 1'b0;
    bus.y_valid  = 1'b0;
    tick();
    bus.y_valid = 1'b1;
    tick();
    tick();
    check("collide_line_done", 64'(line_cnt), 64'(lc));
    check("collide_frame_done", 64'(frame_cnt), 64'(fc));
    vec = '{0, 1, 2, 3, 4, 5, 6, 7};
    burst(8);

    // Reset mid line 2
    frame_start();
    fill_line(0, 8);
    burst(8);
    fill_line(1, 8);
    burst(8);
    for (int i = 0; i < 3; i++) begin
      bus.addr_ena = 1'b1;
      expect_rd(16 + i);
      tick();
    end
    rst = 1'b0;
    tick();
    check("midrst_ram_addr", 64'(bus.ram_addr), 64'd0);
    check("midrst_line_done", {63'd0, bus.line_done}, 64'd0);
    rst = 1'b1;
    bus.addr_ena = 1'b0;
    tick();
    tick();
    vec = {};
    burst(8);
    frame_start();
    fill_line(0, 8);
    burst(8);

    tick(); tick(); tick();
    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
